// File: rtl/cpu_sequencer_pkg.sv
// Shared types for the multi-cycle sequencer: state encoding, output bundle
// and the Moore output decode.
package cpu_sequencer_pkg;

  typedef enum logic [3:0] {
    ST_IDLE   = 4'd0,
    ST_FETCH  = 4'd1,
    ST_DECODE = 4'd2,
    ST_EXEC   = 4'd3,
    ST_MEM    = 4'd4,
    ST_WB     = 4'd5,
    ST_SRST   = 4'd6,
    ST_HALTED = 4'd7,
    ST_FAULT  = 4'd8
  } seq_state_e;

  typedef struct packed {
    logic imem_req;
    logic alu_en;
    logic dmem_req;
    logic dmem_we;
    logic rf_we;
    logic pc_en;
    logic soft_reset;
    logic halted;
    logic fault;
  } seq_out_t;

  // Qualifier inputs are stable from DECODE through WB, so sampling them
  // on entry to MEM/WB gives the same value they hold during that state.
  function automatic seq_out_t decode_outputs(input seq_state_e st,
                                              input logic       mem_write,
                                              input logic       writes_reg);
    seq_out_t o;
    o = '0;
    case (st)
      ST_FETCH:  o.imem_req   = 1'b1;
      ST_EXEC:   o.alu_en     = 1'b1;
      ST_MEM: begin
        o.dmem_req = 1'b1;
        o.dmem_we  = mem_write;
      end
      ST_WB: begin
        o.pc_en = 1'b1;
        o.rf_we = writes_reg;
      end
      ST_SRST:   o.soft_reset = 1'b1;
      ST_HALTED: o.halted     = 1'b1;
      ST_FAULT:  o.fault      = 1'b1;
      default:   o            = '0;
    endcase
    return o;
  endfunction

endpackage

// File: rtl/cpu_sequencer_wait.sv
// Memory wait timer: counts unacknowledged request cycles and flags when the
// final permitted wait cycle has been reached.
module wait_timer #(
  parameter int unsigned TMR_W = 8,
  parameter int unsigned LIMIT = 16
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic clear_i,
  input  logic count_i,
  output logic expired_o
);

  logic [TMR_W-1:0] cnt_q;

  assign expired_o = (cnt_q == TMR_W'(LIMIT - 1));

  // Wait-cycle counter; holds at the limit so it can never wrap.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      cnt_q <= '0;
    end else if (clear_i) begin
      cnt_q <= '0;
    end else if (count_i && !expired_o) begin
      cnt_q <= cnt_q + TMR_W'(1);
    end else begin
      cnt_q <= cnt_q;
    end
  end

endmodule

// File: rtl/cpu_sequencer.sv
// Multi-cycle FETCH/DECODE/EXEC/MEM/WB control FSM with memory handshakes,
// halt, soft reset, single-step and memory timeout handling.
module cpu_sequencer
  import cpu_sequencer_pkg::*;
#(
  parameter int unsigned MEM_TIMEOUT = 16,
  parameter int unsigned TMR_W       = 8
) (
  input  logic clk,
  input  logic reset,
  input  logic run,
  input  logic step_mode,
  input  logic step,
  input  logic imem_ack,
  input  logic dmem_ack,
  input  logic dec_writes_reg,
  input  logic dec_mem_op,
  input  logic dec_mem_write,
  input  logic halt_cmd,
  input  logic rst_cmd,
  output logic imem_req,
  output logic ir_load,
  output logic alu_en,
  output logic dmem_req,
  output logic dmem_we,
  output logic rf_we,
  output logic pc_en,
  output logic soft_reset,
  output logic halted,
  output logic fault
);

  seq_state_e state_q, state_d;
  seq_out_t   out_q;
  logic       in_wait_s, ack_s, expired_s;

  // Which handshake is live in the current state; acks elsewhere are ignored.
  always_comb begin
    in_wait_s = 1'b0;
    ack_s     = 1'b0;
    if (state_q == ST_FETCH) begin
      in_wait_s = 1'b1;
      ack_s     = imem_ack;
    end else if (state_q == ST_MEM) begin
      in_wait_s = 1'b1;
      ack_s     = dmem_ack;
    end else begin
      in_wait_s = 1'b0;
      ack_s     = 1'b0;
    end
  end

  wait_timer #(
    .TMR_W (TMR_W),
    .LIMIT (MEM_TIMEOUT)
  ) u_wait_timer (
    .clk_i     (clk),
    .rst_i     (reset),
    .clear_i   (!in_wait_s),
    .count_i   (in_wait_s && !ack_s),
    .expired_o (expired_s)
  );

  // Next-state selection; an ack on the last permitted cycle beats the timeout.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (run && (!step_mode || step)) state_d = ST_FETCH;
        else                              state_d = ST_IDLE;
      end
      ST_FETCH: begin
        if (imem_ack)       state_d = ST_DECODE;
        else if (expired_s) state_d = ST_FAULT;
        else                state_d = ST_FETCH;
      end
      ST_DECODE: begin
        if (halt_cmd)     state_d = ST_HALTED;
        else if (rst_cmd) state_d = ST_SRST;
        else              state_d = ST_EXEC;
      end
      ST_EXEC: begin
        if (dec_mem_op) state_d = ST_MEM;
        else            state_d = ST_WB;
      end
      ST_MEM: begin
        if (dmem_ack)       state_d = ST_WB;
        else if (expired_s) state_d = ST_FAULT;
        else                state_d = ST_MEM;
      end
      ST_WB: begin
        if (step_mode || !run) state_d = ST_IDLE;
        else                   state_d = ST_FETCH;
      end
      ST_SRST:   state_d = ST_FETCH;
      ST_HALTED: state_d = ST_HALTED;
      ST_FAULT:  state_d = ST_FAULT;
      default:   state_d = ST_FAULT;
    endcase
  end

  // State and output registers; outputs are decoded from the state being entered.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_IDLE;
      out_q   <= '0;
    end else begin
      state_q <= state_d;
      out_q   <= decode_outputs(state_d, dec_mem_write, dec_writes_reg);
    end
  end

  assign ir_load    = (state_q == ST_FETCH) && imem_ack;
  assign imem_req   = out_q.imem_req;
  assign alu_en     = out_q.alu_en;
  assign dmem_req   = out_q.dmem_req;
  assign dmem_we    = out_q.dmem_we;
  assign rf_we      = out_q.rf_we;
  assign pc_en      = out_q.pc_en;
  assign soft_reset = out_q.soft_reset;
  assign halted     = out_q.halted;
  assign fault      = out_q.fault;

endmodule

// File: tb/tb_cpu_sequencer.sv
// Directed bench for cpu_sequencer: state traces inferred from the output bundle.
module tb_cpu_sequencer;

  localparam logic [8:0] O_NONE  = 9'b0_0000_0000;
  localparam logic [8:0] O_FETCH = 9'b1_0000_0000;
  localparam logic [8:0] O_EXEC  = 9'b0_1000_0000;
  localparam logic [8:0] O_DREQ  = 9'b0_0100_0000;
  localparam logic [8:0] O_DWE   = 9'b0_0010_0000;
  localparam logic [8:0] O_RF    = 9'b0_0001_0000;
  localparam logic [8:0] O_PC    = 9'b0_0000_1000;
  localparam logic [8:0] O_SRST  = 9'b0_0000_0100;
  localparam logic [8:0] O_HALT  = 9'b0_0000_0010;
  localparam logic [8:0] O_FAULT = 9'b0_0000_0001;

  logic clk = 1'b0;
  logic reset, run, step_mode, step, imem_ack, dmem_ack;
  logic dec_writes_reg, dec_mem_op, dec_mem_write, halt_cmd, rst_cmd;
  logic imem_req, ir_load, alu_en, dmem_req, dmem_we, rf_we, pc_en;
  logic soft_reset, halted, fault;
  logic [8:0] obs;
  int tests_run  = 0;
  int tests_fail = 0;
  int pc_count   = 0;
  int pc_base;

  always #5 clk = ~clk;

  cpu_sequencer #(.MEM_TIMEOUT(16), .TMR_W(8)) dut (
    .clk(clk), .reset(reset), .run(run), .step_mode(step_mode), .step(step),
    .imem_ack(imem_ack), .dmem_ack(dmem_ack), .dec_writes_reg(dec_writes_reg),
    .dec_mem_op(dec_mem_op), .dec_mem_write(dec_mem_write), .halt_cmd(halt_cmd),
    .rst_cmd(rst_cmd), .imem_req(imem_req), .ir_load(ir_load), .alu_en(alu_en),
    .dmem_req(dmem_req), .dmem_we(dmem_we), .rf_we(rf_we), .pc_en(pc_en),
    .soft_reset(soft_reset), .halted(halted), .fault(fault)
  );

  assign obs = {imem_req, alu_en, dmem_req, dmem_we, rf_we, pc_en, soft_reset, halted, fault};

  always @(posedge clk) if (pc_en) pc_count <= pc_count + 1;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_fail++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    run = 1'b0; step_mode = 1'b0; step = 1'b0; imem_ack = 1'b0; dmem_ack = 1'b0;
    dec_writes_reg = 1'b0; dec_mem_op = 1'b0; dec_mem_write = 1'b0;
    halt_cmd = 1'b0; rst_cmd = 1'b0;
  endtask

  task automatic do_reset();
    clear_inputs();
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
  endtask

  initial begin
    // 1: ADDI, zero-wait, back-to-back
    do_reset();
    check("reset_outs", {23'd0, obs}, {23'd0, O_NONE});
    check("reset_irload", {31'd0, ir_load}, 32'd0);
    run = 1'b1; imem_ack = 1'b1; dmem_ack = 1'b1; dec_writes_reg = 1'b1;
    tick(); check("t1_fetch", {23'd0, obs}, {23'd0, O_FETCH});
    check("t1_irload", {31'd0, ir_load}, 32'd1);
    tick(); check("t1_decode", {23'd0, obs}, {23'd0, O_NONE});
    check("t1_irload_dec", {31'd0, ir_load}, 32'd0);
    tick(); check("t1_exec", {23'd0, obs}, {23'd0, O_EXEC});
    tick(); check("t1_wb", {23'd0, obs}, {23'd0, O_PC | O_RF});
    tick(); check("t1_fetch2", {23'd0, obs}, {23'd0, O_FETCH});

    // 2: store with 3 wait cycles; run dropped mid-instruction
    do_reset();
    run = 1'b1; imem_ack = 1'b1; dec_mem_op = 1'b1; dec_mem_write = 1'b1;
    tick(); check("t2_fetch", {23'd0, obs}, {23'd0, O_FETCH});
    tick(); check("t2_decode", {23'd0, obs}, {23'd0, O_NONE});
    tick(); check("t2_exec", {23'd0, obs}, {23'd0, O_EXEC});
    run = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick(); check("t2_mem", {23'd0, obs}, {23'd0, O_DREQ | O_DWE});
      if (i == 3) dmem_ack = 1'b1;
    end
    tick(); check("t2_wb_norf", {23'd0, obs}, {23'd0, O_PC});
    dmem_ack = 1'b0;
    tick(); check("t2_idle", {23'd0, obs}, {23'd0, O_NONE});
    tick(); check("t2_idle_hold", {23'd0, obs}, {23'd0, O_NONE});

    // 3: imem never acks -> FAULT after 16 FETCH cycles, absorbing
    do_reset();
    run = 1'b1;
    for (int i = 0; i < 16; i++) begin
      tick(); check("t3_fetch_wait", {23'd0, obs}, {23'd0, O_FETCH});
    end
    tick(); check("t3_fault", {23'd0, obs}, {23'd0, O_FAULT});
    imem_ack = 1'b1; step = 1'b1; run = 1'b0;
    repeat (3) tick();
    check("t3_fault_hold", {23'd0, obs}, {23'd0, O_FAULT});
    do_reset();
    check("t3_reset_idle", {23'd0, obs}, {23'd0, O_NONE});

    // 3b: ack on the last allowed wait cycle wins over the timeout
    run = 1'b1;
    for (int i = 0; i < 16; i++) begin
      tick(); check("t3b_fetch_wait", {23'd0, obs}, {23'd0, O_FETCH});
    end
    imem_ack = 1'b1;
    tick(); imem_ack = 1'b0;
    check("t3b_ack_wins", {23'd0, obs}, {23'd0, O_NONE});
    tick(); check("t3b_exec", {23'd0, obs}, {23'd0, O_EXEC});

    // 4: HALT (beats rst_cmd), absorbing until reset
    do_reset();
    run = 1'b1; imem_ack = 1'b1; halt_cmd = 1'b1; rst_cmd = 1'b1;
    tick(); tick();
    check("t4_decode", {23'd0, obs}, {23'd0, O_NONE});
    tick(); check("t4_halted", {23'd0, obs}, {23'd0, O_HALT});
    for (int i = 0; i < 4; i++) begin
      run = i[0]; step = ~i[0];
      tick(); check("t4_halt_hold", {23'd0, obs}, {23'd0, O_HALT});
    end
    do_reset();
    check("t4_reset_idle", {23'd0, obs}, {23'd0, O_NONE});

    // 5: single-step, three pulses, one mid-instruction
    do_reset();
    step_mode = 1'b1; run = 1'b1; imem_ack = 1'b1; dec_writes_reg = 1'b1;
    pc_base = pc_count;
    tick(); check("t5_wait_step", {23'd0, obs}, {23'd0, O_NONE});
    step = 1'b1; tick(); step = 1'b0;
    check("t5_fetch1", {23'd0, obs}, {23'd0, O_FETCH});
    tick(); step = 1'b1;
    tick(); step = 1'b0;
    check("t5_exec1", {23'd0, obs}, {23'd0, O_EXEC});
    tick(); check("t5_wb1", {23'd0, obs}, {23'd0, O_PC | O_RF});
    tick(); check("t5_idle1", {23'd0, obs}, {23'd0, O_NONE});
    tick(); check("t5_no_queue", {23'd0, obs}, {23'd0, O_NONE});
    step = 1'b1; tick(); step = 1'b0;
    check("t5_fetch2", {23'd0, obs}, {23'd0, O_FETCH});
    tick(); tick(); tick();
    check("t5_wb2", {23'd0, obs}, {23'd0, O_PC | O_RF});
    tick(); check("t5_idle2", {23'd0, obs}, {23'd0, O_NONE});
    tick(); tick();
    check("t5_instr_count", pc_count - pc_base, 32'd2);

    // 6: soft reset pulse, then async reset mid-MEM
    do_reset();
    run = 1'b1; imem_ack = 1'b1; rst_cmd = 1'b1;
    tick(); tick();
    tick(); check("t6_srst", {23'd0, obs}, {23'd0, O_SRST});
    rst_cmd = 1'b0; dec_mem_op = 1'b1;
    tick(); check("t6_refetch", {23'd0, obs}, {23'd0, O_FETCH});
    tick(); tick();
    tick(); check("t6_mem", {23'd0, obs}, {23'd0, O_DREQ});
    #2 reset = 1'b1;
    #1 check("t6_async_rst", {23'd0, obs}, {23'd0, O_NONE});
    @(posedge clk); #1 reset = 1'b0;
    check("t6_after_rst", {23'd0, obs}, {23'd0, O_NONE});

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_fail);
    $finish;
  end

endmodule
